fpcvt_expand: RTL and testbench

- Downstream stage of the 12-bit two's-complement to floating-point converter.
- Consumes the sign bit, 3-bit exponent and 4-bit significand, and reconstructs the 12-bit two's-complement value D = (S ? -1 : 1) * F * 2^E with an iterative shifter FSM.
- Used for round-trip checking and to drive the display/compare logic with the value the float format actually represents.
- Valid/ready handshake on both sides; one conversion in flight at a time.

---
 rtl/fpcvt_expand.sv | 93 +++++++++
 tb/tb_fpcvt_expand.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_expand.sv
// Rebuilds the two's-complement value (S ? -1 : 1) * F * 2^E from the sign/exponent/significand float fields.
// Build option FPCVT_EXPAND_BARREL_EN loads F << E in one step instead of shifting once per cycle.
`timescale 1ns/1ps
module fpcvt_expand #(
   parameter int OUT_W = 12,
   parameter int E_W   = 3,
   parameter int F_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             S,
   input  logic [E_W-1:0]   E,
   input  logic [F_W-1:0]   F,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] D_out,
   output logic             busy
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // valid stays high with its payload stable until that edge.
   typedef enum logic [1:0] {IDLE, SHIFT, NEG, HOLD} state_t;

   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   state_t           state_q;
   logic             sign_q;
   logic [E_W-1:0]   cnt_q;
   logic [OUT_W-1:0] mag_q;
   logic [OUT_W-1:0] mag_d;
   logic [OUT_W-1:0] d_out_q;
   logic             out_valid_q;

`ifdef FPCVT_EXPAND_BARREL_EN
   assign mag_d = OUT_W'(F) << E;
`else
   assign mag_d = OUT_W'(F);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         cnt_q       <= '0;
         mag_q       <= '0;
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= S;
                  cnt_q  <= E;
                  mag_q  <= mag_d;
`ifdef FPCVT_EXPAND_BARREL_EN
                  state_q <= NEG;
`else
                  state_q <= (E != '0) ? SHIFT : NEG;
`endif
               end
            end
            SHIFT: begin
               mag_q <= mag_q << 1;
               cnt_q <= cnt_q - E_W'(1);
               if (cnt_q == E_W'(1)) begin
                  state_q <= NEG;
               end
            end
            NEG: begin
               // Negating a zero magnitude wraps back to zero, so there is no negative zero.
               d_out_q     <= sign_q ? (~mag_q + ONE) : mag_q;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign D_out     = d_out_q;

endmodule

// File: tb/tb_fpcvt_expand.sv
// Bench for fpcvt_expand: directed corner cases, backpressure, mid-conversion reset,
// a shuffled sweep of every S/E/F code and randomized stalls against an arithmetic reference.
`timescale 1ns/1ps
module tb_fpcvt_expand;

   localparam int OUT_W = 12;
   localparam int E_W   = 3;
   localparam int F_W   = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             S;
   logic [E_W-1:0]   E;
   logic [F_W-1:0]   F;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] D_out;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   logic [OUT_W-1:0] exp_q[$];

   fpcvt_expand #(.OUT_W(OUT_W), .E_W(E_W), .F_W(F_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .S         (S),
      .E         (E),
      .F         (F),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D_out     (D_out),
      .busy      (busy)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // Reference model: plain signed arithmetic, wrapped to OUT_W bits
   function automatic logic [OUT_W-1:0] ref_value(input int s, input int e, input int f);
      int v;
      v = f * (1 << e);
      if (s != 0) v = -v;
      return v[OUT_W-1:0];
   endfunction

   function automatic int ref_latency(input int e);
`ifdef FPCVT_EXPAND_BARREL_EN
      return 1;
`else
      return e + 1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Driver: present one input and hold it until accepted
   task automatic send(input int s, input int e, input int f);
      logic acc;
      S        = s[0];
      E        = e[E_W-1:0];
      F        = f[F_W-1:0];
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      acc_cyc  = cyc;
      check("accept", 32'(acc), 32'(1));
      exp_q.push_back(ref_value(s, e, f));
   endtask

   task automatic wait_valid(output int lat);
      logic seen;
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         seen = out_valid;
      end
      check("out_valid_timeout", 32'(seen), 32'(1));
   endtask

   // Scoreboard: compare the result and latency, then complete the handshake
   task automatic collect(input int e);
      int lat;
      logic [OUT_W-1:0] exp_v;
      wait_valid(lat);
      check("latency", 32'(lat), 32'(ref_latency(e)));
      exp_v = exp_q.pop_front();
      check("d_out", 32'(D_out), 32'(exp_v));
      if (out_ready) begin
         @(posedge clk);
         #1;
         check("in_ready_after", 32'(in_ready), 32'(1));
         check("out_valid_after", 32'(out_valid), 32'(0));
      end
   endtask

   initial begin
      int lat;
      int order[256];
      int prev_acc;
      int prev_e;
      int stall;
      logic stale;
      logic [OUT_W-1:0] held;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      S = 1'b0; E = '0; F = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_d_out", 32'(D_out), 32'(0));

      // Directed values
      out_ready = 1'b1;
      send(0, 0, 5);  collect(0);
      check("d_e0f5_const", 32'(D_out), 32'h005);
      send(1, 7, 15); collect(7);
      check("d_neg1920_const", 32'(D_out), 32'h880);
      send(0, 3, 9);  collect(3);
      check("d_e3f9_const", 32'(D_out), 32'h048);
      send(1, 3, 0);  collect(3);
      check("d_neg_zero_const", 32'(D_out), 32'h000);

      // Backpressure while the producer keeps offering changing inputs
      out_ready = 1'b0;
      send(0, 2, 3);
      wait_valid(lat);
      check("bp_latency", 32'(lat), 32'(ref_latency(2)));
      held = exp_q.pop_front();
      check("bp_d_out", 32'(D_out), 32'(held));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         S        = 1'($urandom_range(0, 1));
         E        = E_W'($urandom_range(0, 7));
         F        = F_W'($urandom_range(0, 15));
         in_valid = 1'b1;
         @(negedge clk);
         check("bp_hold_d_out", 32'(D_out), 32'(held));
         check("bp_hold_in_ready", 32'(in_ready), 32'(0));
         check("bp_hold_out_valid", 32'(out_valid), 32'(1));
      end
      @(posedge clk);
      #1;
      S = 1'b1; E = E_W'(1); F = F_W'(7);
      out_ready = 1'b1;
      exp_q.push_back(ref_value(1, 1, 7));
      @(posedge clk);
      #1;
      check("bp_hs_in_ready", 32'(in_ready), 32'(1));
      check("bp_hs_busy", 32'(busy), 32'(0));
      check("bp_hs_out_valid", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_pending_accepted", 32'(busy), 32'(1));
      collect(1);
      check("bp_pending_value", 32'(D_out), 32'hFF2);

      // Reset in the third shift cycle of an E=6 conversion
      send(0, 6, 1);
      exp_q.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mid_rst_out_valid", 32'(out_valid), 32'(0));
      check("mid_rst_d_out", 32'(D_out), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_in_ready", 32'(in_ready), 32'(1));
      stale = 1'b0;
      repeat (12) begin
         @(negedge clk);
         stale = stale | out_valid;
      end
      check("mid_rst_no_stale", 32'(stale), 32'(0));
      @(posedge clk);
      #1;

      // Every S/E/F code, shuffled, back-to-back
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int t;
         j = int'($urandom_range(0, i));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      prev_acc = 0;
      prev_e   = 0;
      for (int i = 0; i < 256; i++) begin
         int idx;
         idx = order[i];
         send(int'(idx[7]), int'(idx[6:4]), int'(idx[3:0]));
         if (i > 0) check("throughput", 32'(acc_cyc - prev_acc), 32'(ref_latency(prev_e) + 2));
         prev_acc = acc_cyc;
         prev_e   = int'(idx[6:4]);
         collect(int'(idx[6:4]));
      end

      // Random values with random output stalls
      for (int i = 0; i < 40; i++) begin
         int s;
         int e;
         int f;
         s = int'($urandom_range(0, 1));
         e = int'($urandom_range(0, 7));
         f = int'($urandom_range(0, 15));
         out_ready = 1'b0;
         send(s, e, f);
         wait_valid(lat);
         check("rnd_latency", 32'(lat), 32'(ref_latency(e)));
         held = exp_q.pop_front();
         check("rnd_d_out", 32'(D_out), 32'(held));
         stall = int'($urandom_range(0, 3));
         repeat (stall) begin
            @(posedge clk);
            #1;
         end
         check("rnd_stall_d_out", 32'(D_out), 32'(held));
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check("rnd_in_ready_after", 32'(in_ready), 32'(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
